// File: rtl/ac_motor_vector_dwell.sv
// Space-vector dwell-time calculator: T1/T2/T0 from amplitude and sector sines using one shared multiplier.
// Define OVERMOD_SCALE_EN to rescale overmodulated results with a restoring divider instead of clamping.
module ac_motor_vector_dwell #(
    parameter int BITS   = 12,
    parameter int F_CLK  = 100000000,
    parameter int F_TAST = 5000,
    parameter int T_TAST = F_CLK / F_TAST,
    parameter int TW     = 15
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic [BITS-1:0] U_STR,
    input  logic [BITS-1:0] SIN_POSITIVE,
    input  logic [BITS-1:0] SIN_NEGATIVE,
    input  logic [2:0]      SECTOR,
    output logic            READY,
    output logic            VALID,
    output logic [TW-1:0]   T_1,
    output logic [TW-1:0]   T_2,
    output logic [TW-1:0]   T_0,
    output logic [2:0]      SECTOR_OUT,
    output logic            OVERMOD,
    output logic            ERR
);

`ifdef OVERMOD_SCALE_EN
    localparam int MB = (BITS > TW) ? BITS : TW;
    localparam int CW = $clog2(TW + 1);
`else
    localparam int MB = BITS;
`endif
    localparam int AW = BITS + TW;
    localparam int PW = AW + MB;

    localparam logic [TW-1:0] T_TAST_W = TW'(T_TAST);
    localparam logic [TW:0]   T_TAST_S = (TW + 1)'(T_TAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_K,
        S_MUL_1,
        S_MUL_2,
        S_CHECK
`ifdef OVERMOD_SCALE_EN
        , S_DIV
`endif
    } state_t;

    state_t          state;
    logic [BITS-1:0] u_reg;
    logic [BITS-1:0] sin_pos_reg;
    logic [BITS-1:0] sin_neg_reg;
    logic [2:0]      sector_reg;
    logic [AW-1:0]   k_reg;
    logic [TW-1:0]   t1_reg;
    logic [TW-1:0]   t2_reg;

    logic [AW-1:0]   mul_a;
    logic [MB-1:0]   mul_b;
    logic [PW-1:0]   prod;
    logic [TW-1:0]   t_prod;
    logic [TW:0]     sum;
    logic            sector_bad;

`ifdef OVERMOD_SCALE_EN
    logic [TW:0]     div_rem;
    logic [TW-1:0]   div_quo;
    logic [TW:0]     div_den;
    logic [CW-1:0]   div_cnt;
    logic [TW+1:0]   div_shift;
    logic [TW+1:0]   div_next_rem;
    logic            div_ge;
    logic [TW-1:0]   div_next_quo;
`else
    logic [TW-1:0]   t1_clamped;
`endif

    // The single multiplier is time-shared; its operands follow the state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_MUL_K: begin
                mul_a = AW'(T_TAST);
                mul_b = MB'(u_reg);
            end
            S_MUL_1: begin
                mul_a = k_reg;
                mul_b = MB'(sin_neg_reg);
            end
            S_MUL_2: begin
                mul_a = k_reg;
                mul_b = MB'(sin_pos_reg);
            end
`ifdef OVERMOD_SCALE_EN
            S_DIV: begin
                mul_a = AW'(T_TAST);
                mul_b = MB'(t1_reg);
            end
`endif
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    assign prod       = {{MB{1'b0}}, mul_a} * {{AW{1'b0}}, mul_b};
    assign t_prod     = prod[2*BITS +: TW];
    assign sum        = {1'b0, t1_reg} + {1'b0, t2_reg};
    assign sector_bad = (sector_reg == 3'd0) || (sector_reg == 3'd7);

`ifdef OVERMOD_SCALE_EN
    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        div_shift    = {div_rem, div_quo[TW-1]};
        div_ge       = (div_shift >= {1'b0, div_den});
        div_next_rem = div_ge ? (div_shift - {1'b0, div_den}) : div_shift;
        div_next_quo = {div_quo[TW-2:0], div_ge};
    end
`else
    assign t1_clamped = (t1_reg > T_TAST_W) ? T_TAST_W : t1_reg;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            READY       <= 1'b1;
            VALID       <= 1'b0;
            T_1         <= '0;
            T_2         <= '0;
            T_0         <= '0;
            SECTOR_OUT  <= '0;
            OVERMOD     <= 1'b0;
            ERR         <= 1'b0;
            u_reg       <= '0;
            sin_pos_reg <= '0;
            sin_neg_reg <= '0;
            sector_reg  <= '0;
            k_reg       <= '0;
            t1_reg      <= '0;
            t2_reg      <= '0;
`ifdef OVERMOD_SCALE_EN
            div_rem     <= '0;
            div_quo     <= '0;
            div_den     <= '0;
            div_cnt     <= '0;
`endif
        end else begin
            VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        u_reg       <= U_STR;
                        sin_pos_reg <= SIN_POSITIVE;
                        sin_neg_reg <= SIN_NEGATIVE;
                        sector_reg  <= SECTOR;
                        READY       <= 1'b0;
                        state       <= S_MUL_K;
                    end
                end
                S_MUL_K: begin
                    k_reg <= prod[AW-1:0];
                    state <= S_MUL_1;
                end
                S_MUL_1: begin
                    t1_reg <= t_prod;
                    state  <= S_MUL_2;
                end
                S_MUL_2: begin
                    t2_reg <= t_prod;
                    state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (sector_bad) begin
                        T_1        <= '0;
                        T_2        <= '0;
                        T_0        <= T_TAST_W;
                        ERR        <= 1'b1;
                        OVERMOD    <= 1'b0;
                        SECTOR_OUT <= sector_reg;
                        VALID      <= 1'b1;
                        READY      <= 1'b1;
                        state      <= S_IDLE;
                    end else if (sum <= T_TAST_S) begin
                        T_1        <= t1_reg;
                        T_2        <= t2_reg;
                        T_0        <= T_TAST_W - sum[TW-1:0];
                        ERR        <= 1'b0;
                        OVERMOD    <= 1'b0;
                        SECTOR_OUT <= sector_reg;
                        VALID      <= 1'b1;
                        READY      <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
`ifdef OVERMOD_SCALE_EN
                        div_den <= sum;
                        div_cnt <= '0;
                        state   <= S_DIV;
`else
                        T_1        <= t1_clamped;
                        T_2        <= T_TAST_W - t1_clamped;
                        T_0        <= '0;
                        ERR        <= 1'b0;
                        OVERMOD    <= 1'b1;
                        SECTOR_OUT <= sector_reg;
                        VALID      <= 1'b1;
                        READY      <= 1'b1;
                        state      <= S_IDLE;
`endif
                    end
                end
`ifdef OVERMOD_SCALE_EN
                // First DIV cycle loads t1*T_TAST from the multiplier, then TW quotient bits follow.
                S_DIV: begin
                    if (div_cnt == '0) begin
                        div_rem <= {1'b0, prod[2*TW-1:TW]};
                        div_quo <= prod[TW-1:0];
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_rem <= div_next_rem[TW:0];
                        div_quo <= div_next_quo;
                        if (div_cnt == CW'(TW)) begin
                            T_1        <= div_next_quo;
                            T_2        <= T_TAST_W - div_next_quo;
                            T_0        <= '0;
                            ERR        <= 1'b0;
                            OVERMOD    <= 1'b1;
                            SECTOR_OUT <= sector_reg;
                            VALID      <= 1'b1;
                            READY      <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    READY <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_motor_vector_dwell.sv
// Directed bench for ac_motor_vector_dwell with hand-computed dwell times at default parameters.
// Expected overmodulation results follow OVERMOD_SCALE_EN when it is defined for the build.
module tb_ac_motor_vector_dwell;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] u_str;
    logic [11:0] sin_pos;
    logic [11:0] sin_neg;
    logic [2:0]  sector;
    logic        ready;
    logic        valid;
    logic [14:0] t_1;
    logic [14:0] t_2;
    logic [14:0] t_0;
    logic [2:0]  sector_out;
    logic        overmod;
    logic        err;

    int vectors;
    int miscompares;

    ac_motor_vector_dwell dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .START        (start),
        .U_STR        (u_str),
        .SIN_POSITIVE (sin_pos),
        .SIN_NEGATIVE (sin_neg),
        .SECTOR       (sector),
        .READY        (ready),
        .VALID        (valid),
        .T_1          (t_1),
        .T_2          (t_2),
        .T_0          (t_0),
        .SECTOR_OUT   (sector_out),
        .OVERMOD      (overmod),
        .ERR          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Issues one request from the current post-edge point and returns the edge count until VALID.
    task automatic applyStimulus(input logic [11:0] u, input logic [11:0] sn, input logic [11:0] sp,
                                 input logic [2:0] sec, output int lat);
        int guard;
        guard = 0;
        while (!ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("ready_before_start", ready, 1);
        u_str   = u;
        sin_neg = sn;
        sin_pos = sp;
        sector  = sec;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) checkOutput("ready_drop", ready, 0);
            if (valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) checkOutput("valid_timeout", valid, 1);
    endtask

    task automatic checkResult(input string tag, input int lat, input int exp_lat,
                               input int e1, input int e2, input int e0,
                               input int esec, input int eom, input int eerr);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_t1"}, t_1, e1);
        checkOutput({tag, "_t2"}, t_2, e2);
        checkOutput({tag, "_t0"}, t_0, e0);
        checkOutput({tag, "_sector"}, sector_out, esec);
        checkOutput({tag, "_overmod"}, overmod, eom);
        checkOutput({tag, "_err"}, err, eerr);
        checkOutput({tag, "_ready"}, ready, 1);
    endtask

    initial begin
        int lat;
        int count;
        int om_lat;
        int om_t1;
        int om_t2;

        vectors     = 0;
        miscompares = 0;
`ifdef OVERMOD_SCALE_EN
        om_lat = 20;
        om_t1  = 13332;
        om_t2  = 6668;
`else
        om_lat = 4;
        om_t1  = 19990;
        om_t2  = 10;
`endif

        rst_n   = 1'b0;
        start   = 1'b0;
        u_str   = '0;
        sin_pos = '0;
        sin_neg = '0;
        sector  = '0;
        #12;
        checkOutput("rst_ready", ready, 1);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_t1", t_1, 0);
        checkOutput("rst_t2", t_2, 0);
        checkOutput("rst_t0", t_0, 0);
        checkOutput("rst_sector", sector_out, 0);
        checkOutput("rst_overmod", overmod, 0);
        checkOutput("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(12'd2048, 12'd2048, 12'd1024, 3'd3, lat);
        checkResult("nominal", lat, 4, 5000, 2500, 12500, 3, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("valid_one_cycle", valid, 0);
        checkOutput("hold_t1", t_1, 5000);

        applyStimulus(12'd4095, 12'd4095, 12'd0, 3'd1, lat);
        checkResult("fullscale", lat, 4, 19990, 0, 10, 1, 0, 0);

        applyStimulus(12'd4095, 12'd4095, 12'd2048, 3'd2, lat);
        checkResult("overmod", lat, om_lat, om_t1, om_t2, 0, 2, 1, 0);

        applyStimulus(12'd1000, 12'd300, 12'd700, 3'd7, lat);
        checkResult("sector7", lat, 4, 0, 0, 20000, 7, 0, 1);

        applyStimulus(12'd2048, 12'd2048, 12'd1024, 3'd0, lat);
        checkResult("sector0", lat, 4, 0, 0, 20000, 0, 0, 1);

        applyStimulus(12'd2048, 12'd1024, 12'd2048, 3'd5, lat);
        checkResult("err_clear", lat, 4, 2500, 5000, 12500, 5, 0, 0);

        // START held high from a READY cycle: results at edges 4, 9, 14, 19.
        u_str   = 12'd2048;
        sin_neg = 12'd2048;
        sin_pos = 12'd1024;
        sector  = 3'd6;
        start   = 1'b1;
        count   = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (valid) count++;
        end
        start = 1'b0;
        checkOutput("b2b_count", count, 4);
        checkOutput("b2b_t1", t_1, 5000);
        checkOutput("b2b_sector", sector_out, 6);

        // A START pulse while in MUL_1 must not be queued or disturb the latched request.
        u_str   = 12'd2048;
        sin_neg = 12'd2048;
        sin_pos = 12'd1024;
        sector  = 3'd4;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        u_str   = 12'd4095;
        sin_neg = 12'd4095;
        sin_pos = 12'd4095;
        sector  = 3'd1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        count = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (valid) count++;
        end
        checkOutput("ignored_start_count", count, 1);
        checkOutput("ignored_start_t1", t_1, 5000);
        checkOutput("ignored_start_t2", t_2, 2500);
        checkOutput("ignored_start_sector", sector_out, 4);

        // Reset while in MUL_2 clears everything at once and yields no VALID.
        u_str   = 12'd2048;
        sin_neg = 12'd2048;
        sin_pos = 12'd1024;
        sector  = 3'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_t1", t_1, 0);
        checkOutput("midrst_t0", t_0, 0);
        checkOutput("midrst_sector", sector_out, 0);
        checkOutput("midrst_ready", ready, 1);
        checkOutput("midrst_valid", valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (valid) count++;
        end
        checkOutput("midrst_no_valid", count, 0);
        checkOutput("midrst_ready_after", ready, 1);

        applyStimulus(12'd4095, 12'd4095, 12'd0, 3'd1, lat);
        checkResult("after_rst", lat, 4, 19990, 0, 10, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ac_motor_vector_dwell.md
Name: ac_motor_vector_dwell

Overview:
Next-generation space-vector dwell-time calculator for the AC motor vector path.
- Per sample request, computes active-vector times T1 and T2 and the zero-vector time T0 from modulation amplitude and sector sine terms.
- Adds handshaked start/valid, sector validation and overmodulation limiting.
- Uses one shared multiplier, so results are deterministic and multi-cycle.
- Sits between the angle/sine lookup stage and the PWM switching-sequence generator.

Parameters:
BITS, 12, width of U_STR, SIN_POSITIVE, SIN_NEGATIVE (unsigned, full scale 2**BITS-1)
F_CLK, 100000000, system clock frequency in Hz
F_TAST, 5000, PWM sample frequency in Hz
T_TAST, F_CLK/F_TAST, sample period in clock ticks (default 20000)
TW, 15, width of time outputs; must satisfy T_TAST < 2**TW

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  request; accepted only when READY=1
U_STR  in  BITS  modulation amplitude
SIN_POSITIVE  in  BITS  sin(theta) term for T2
SIN_NEGATIVE  in  BITS  sin(60deg-theta) term for T1
SECTOR  in  3  sector index, valid 1..6
READY  out  1  high in IDLE
VALID  out  1  one-cycle pulse, results updated
T_1  out  TW  dwell time of first active vector, ticks
T_2  out  TW  dwell time of second active vector, ticks
T_0  out  TW  zero-vector time, ticks
SECTOR_OUT  out  3  sector latched with the request
OVERMOD  out  1  set when T1+T2 exceeded T_TAST for this result
ERR  out  1  set when SECTOR was 0 or 7

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; READY=1; VALID=0; T_1=T_2=T_0=0; SECTOR_OUT=0; OVERMOD=0; ERR=0; internal registers cleared. Reset mid-computation aborts it with no VALID.
- States: IDLE -> MUL_K -> MUL_1 -> MUL_2 -> CHECK -> (DIV) -> IDLE.
- IDLE: on START=1, latch U_STR, both sines and SECTOR; READY drops next cycle. START outside IDLE is ignored and not queued.
- MUL_K: K = T_TAST*U_STR, width BITS+TW.
- MUL_1: t1 = (K*SIN_NEGATIVE) >> (2*BITS), full product width 2*BITS+TW, truncation.
- MUL_2: t2 = (K*SIN_POSITIVE) >> (2*BITS).
- CHECK: s = t1+t2, width TW+1.
  - Invalid sector: T_1=0, T_2=0, T_0=T_TAST, ERR=1, OVERMOD=0.
  - s <= T_TAST: T_1=t1, T_2=t2, T_0=T_TAST-s, OVERMOD=0.
  - s = T_TAST exactly: not overmodulated; T_0=0.
  - s > T_TAST: OVERMOD=1 and limiting per Optional Feature.
- Latency: START sampled at edge 0; outputs and VALID update at edge 4 on the non-scaling path. VALID is high for exactly one cycle and READY returns to 1 in the same cycle.
- Outputs, SECTOR_OUT, OVERMOD and ERR hold until the next VALID.
- A new START is accepted in the cycle READY=1, giving back-to-back throughput of one result per 5 cycles.

Optional Feature:
OVERMOD_SCALE_EN
- Defined, overmodulation path:
  - Enter DIV; restoring shift-subtract divider, 1 load cycle + TW iterations.
  - T_1 = floor(t1*T_TAST/s), T_2 = T_TAST-T_1, T_0 = 0.
  - VALID at edge 4+TW+1 (edge 20 at defaults); other paths keep latency 4.
- Undefined:
  - No divider, DIV state absent.
  - T_1 = min(t1, T_TAST), T_2 = T_TAST-T_1, T_0 = 0.
  - Latency 4 on all paths.

Test Plan:
- Nominal: U=2048, S_NEG=2048, S_POS=1024, SECTOR=3 -> VALID at edge 4; T_1=5000, T_2=2500, T_0=12500, OVERMOD=0, ERR=0, SECTOR_OUT=3.
- Full scale, one term: U=4095, S_NEG=4095, S_POS=0, SECTOR=1 -> T_1=19990, T_2=0, T_0=10.
- Overmod: U=4095, S_NEG=4095, S_POS=2048, SECTOR=2 (t1=19990, t2=9997).
  - With OVERMOD_SCALE_EN: VALID at edge 20; T_1=13332, T_2=6668, T_0=0, OVERMOD=1.
  - Without: VALID at edge 4; T_1=19990, T_2=10, T_0=0.
- Invalid sector: SECTOR=7, any U/sines -> T_1=0, T_2=0, T_0=20000, ERR=1.
  - Following valid request clears ERR.
- Handshake: START held high continuously -> one result per 5 cycles; START pulse during MUL_1 ignored; no extra VALID.
- Reset: RST_N low during MUL_2 -> all outputs 0 immediately, READY=1 after release, no VALID.
  - Next request computes correctly.
